// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N independent pushbutton channels sharing one sample-tick
// generator. Each channel has a 2-FF synchroniser, a stable-count debounce filter,
// a debounced level and registered one-clock press/release pulses.
// Optional auto-repeat strobes are built only when KEY_REPEAT_EN is defined;
// otherwise repeat_pulse is constant 0 and no hold counters exist.
module key_debounce_multi #(
   parameter int NKEY         = 4,
   parameter int SR           = 999,
   parameter int STABLE       = 3,
   parameter int ACTIVE_LOW   = 0,
   parameter int LONG_TICKS   = 50,
   parameter int REPEAT_TICKS = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NKEY-1:0] key_in,
   output logic            sample_tick,
   output logic [NKEY-1:0] key_state,
   output logic [NKEY-1:0] press_pulse,
   output logic [NKEY-1:0] release_pulse,
   output logic [NKEY-1:0] repeat_pulse
);

   // SR=0 still needs a one-bit counter that simply sits at zero.
   localparam int            TW          = (SR > 0) ? $clog2(SR + 1) : 1;
   localparam int            CW          = $clog2(STABLE + 1);
   localparam logic [TW-1:0] TICK_RELOAD = TW'(SR);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE - 1);
   localparam logic          IDLE_LVL    = (ACTIVE_LOW != 0);

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   wire [NKEY-1:0] state_w;
   wire [NKEY-1:0] press_w;
   wire [NKEY-1:0] release_w;
   wire [NKEY-1:0] repeat_w;

   assign tick          = (tick_cnt_q == '0);
   assign sample_tick   = tick;
   assign key_state     = state_w;
   assign press_pulse   = press_w;
   assign release_pulse = release_w;
   assign repeat_pulse  = repeat_w;

   // Shared down-counter: reloads on zero, so the tick period is SR+1 clocks.
   always_comb begin
      tick_cnt_d = tick ? TICK_RELOAD : (tick_cnt_q - TW'(1));
   end

   // Tick counter register; reset loads the full period.
   always_ff @(posedge clk) begin
      if (!rst_n) tick_cnt_q <= TICK_RELOAD;
      else        tick_cnt_q <= tick_cnt_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NKEY; gi = gi + 1) begin : gen_key
         logic          sync1_q, sync1_d;
         logic          sync2_q, sync2_d;
         logic          k_s;
         logic          state_q, state_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic          press_q, press_d;
         logic          rel_q, rel_d;
         logic          toggle;

         // Normalise so that 1 always means pressed after synchronisation.
         assign k_s = sync2_q ^ IDLE_LVL;

         // Synchroniser shift and debounce filter: a new level is accepted only
         // after STABLE consecutive ticks that disagree with the current level.
         always_comb begin
            sync1_d = key_in[gi];
            sync2_d = sync1_q;
            state_d = state_q;
            cnt_d   = cnt_q;
            toggle  = 1'b0;
            if (tick) begin
               if (k_s == state_q) begin
                  cnt_d = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  toggle  = 1'b1;
                  state_d = ~state_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            press_d = toggle & ~state_q;
            rel_d   = toggle & state_q;
         end

         // Channel registers; synchronisers reset to the idle level so no
         // false press is seen when reset is released.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sync1_q <= IDLE_LVL;
               sync2_q <= IDLE_LVL;
               state_q <= 1'b0;
               cnt_q   <= '0;
               press_q <= 1'b0;
               rel_q   <= 1'b0;
            end else begin
               sync1_q <= sync1_d;
               sync2_q <= sync2_d;
               state_q <= state_d;
               cnt_q   <= cnt_d;
               press_q <= press_d;
               rel_q   <= rel_d;
            end
         end

         assign state_w[gi]   = state_q;
         assign press_w[gi]   = press_q;
         assign release_w[gi] = rel_q;

`ifdef KEY_REPEAT_EN
         localparam int            HW          = $clog2(LONG_TICKS + 1);
         localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
         localparam logic [HW-1:0] HOLD_RELOAD = HW'(LONG_TICKS - REPEAT_TICKS);

         logic [HW-1:0] hold_q, hold_d;
         logic          rep_q, rep_d;

         // Hold counter: counts ticks while pressed, fires a repeat on reaching
         // LONG_TICKS and reloads so later repeats come every REPEAT_TICKS.
         // A tick that releases the key never emits a repeat.
         always_comb begin
            hold_d = hold_q;
            rep_d  = 1'b0;
            if (!state_q) begin
               hold_d = '0;
            end else if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = HOLD_RELOAD;
                  rep_d  = ~toggle;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end

         // Repeat registers, aligned with press/release pulses.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               hold_q <= '0;
               rep_q  <= 1'b0;
            end else begin
               hold_q <= hold_d;
               rep_q  <= rep_d;
            end
         end

         assign repeat_w[gi] = rep_q;
`else
         // Repeat timing has no effect in this build; the strobe is held low.
         assign repeat_w[gi] = 1'b0 & (LONG_TICKS > REPEAT_TICKS);
`endif
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed testbench for key_debounce_multi (NKEY=4, SR=9, STABLE=3).
// Build with KEY_REPEAT_EN defined to also exercise auto-repeat.
module tb_key_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_in = 4'b0000;
   logic       sample_tick;
   logic [3:0] key_state;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] repeat_pulse;

`ifdef KEY_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   key_debounce_multi #(
      .NKEY(4), .SR(9), .STABLE(3), .ACTIVE_LOW(0),
      .LONG_TICKS(5), .REPEAT_TICKS(2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_in        (key_in),
      .sample_tick   (sample_tick),
      .key_state     (key_state),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   bit         mon_en   = 1'b0;
   logic [3:0] rep_seen     = 4'b0000;
   logic [3:0] overlap_seen = 4'b0000;

   // Whole-run observation of repeat strobes and press/release overlap.
   always @(negedge clk) begin
      if (mon_en) begin
         rep_seen     = rep_seen | repeat_pulse;
         overlap_seen = overlap_seen | (press_pulse & release_pulse);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock; cyc counts cycles since reset release (ticks when cyc%10==9).
   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic goto_phase(input int p);
      while ((cyc % 10) != p) step();
   endtask

   // Run n clocks; at cycle ev (0 = none) expect the given pulses and the
   // level to switch from ks_before to ks_after.
   task automatic run_expect(input string tag, input int n, input int ev,
                             input logic [3:0] p_exp, input logic [3:0] r_exp,
                             input logic [3:0] ks_before, input logic [3:0] ks_after);
      int bad;
      logic [3:0] ep, er, eks;
      bad = 0;
      for (int m = 1; m <= n; m++) begin
         step();
         ep  = (m == ev) ? p_exp : 4'b0000;
         er  = (m == ev) ? r_exp : 4'b0000;
         eks = (ev != 0 && m >= ev) ? ks_after : ks_before;
         if (press_pulse !== ep || release_pulse !== er || key_state !== eks) bad++;
         if (m == ev) begin
            check({tag, "_press"}, press_pulse, p_exp);
            check({tag, "_release"}, release_pulse, r_exp);
            check({tag, "_state"}, key_state, ks_after);
         end
      end
      check({tag, "_bad_cycles"}, bad, 0);
      $display("txn %s: %0d clocks, ends at cyc %0d, key_state=%b", tag, n, cyc, key_state);
   endtask

   initial begin
      int bad;
      logic       exp_tick;
      logic [3:0] exp_rep, exp_rel, exp_ks;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_key_state", key_state, 4'b0000);
      check("rst_press", press_pulse, 4'b0000);
      check("rst_release", release_pulse, 4'b0000);
      check("rst_repeat", repeat_pulse, 4'b0000);
      check("rst_tick", sample_tick, 1'b0);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      cyc    = 0;
      $display("txn reset: released");

      // Tick timing: first at cyc 9, then every 10
      bad = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         exp_tick = (k >= 9) && (((k - 9) % 10) == 0);
         if (sample_tick !== exp_tick) bad++;
         if (k == 8)  check("tick_not_early", sample_tick, 1'b0);
         if (k == 9)  check("tick_first", sample_tick, 1'b1);
         if (k == 19) check("tick_second", sample_tick, 1'b1);
      end
      check("tick_bad_cycles", bad, 0);
      $display("txn tick_timing: cyc %0d", cyc);

      // Idle: no activity for 200 clocks
      run_expect("idle", 200, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Key 0 press and release (set just after a tick: 30-clock latency)
      goto_phase(0);
      key_in[0] = 1'b1;
      run_expect("k0_press", 40, 30, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      key_in[0] = 1'b0;
      run_expect("k0_rel", 40, 30, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

      // Key 1 glitch of 15 clocks covering two ticks: no acceptance
      goto_phase(5);
      key_in[1] = 1'b1;
      run_expect("k1_glitch_hi", 15, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      key_in[1] = 1'b0;
      run_expect("k1_glitch_lo", 20, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Key 1 real press: full 30-clock latency proves the count was cleared
      key_in[1] = 1'b1;
      run_expect("k1_press", 30, 30, 4'b0010, 4'b0000, 4'b0000, 4'b0010);

      // Key 1 hold (repeats only with KEY_REPEAT_EN), release set at +95
      bad = 0;
      for (int m = 1; m <= 150; m++) begin
         step();
         exp_rep = (REP_EN && (m == 50 || m == 70 || m == 90 || m == 110)) ? 4'b0010 : 4'b0000;
         exp_rel = (m == 120) ? 4'b0010 : 4'b0000;
         exp_ks  = (m < 120) ? 4'b0010 : 4'b0000;
         if (repeat_pulse !== exp_rep || release_pulse !== exp_rel ||
             press_pulse !== 4'b0000 || key_state !== exp_ks) bad++;
         if (m == 50)  check("k1_rep_first", repeat_pulse, exp_rep);
         if (m == 60)  check("k1_rep_gap", repeat_pulse, 4'b0000);
         if (m == 70)  check("k1_rep_second", repeat_pulse, exp_rep);
         if (m == 120) begin
            check("k1_rel_pulse", release_pulse, 4'b0010);
            check("k1_rel_state", key_state, 4'b0000);
         end
         if (m == 95) key_in[1] = 1'b0;
      end
      check("k1_hold_bad_cycles", bad, 0);
      $display("txn k1_hold_release: cyc %0d", cyc);

      // Keys 2 and 3 pressed together, then key 3 alone released
      goto_phase(0);
      key_in[3:2] = 2'b11;
      run_expect("k23_press", 40, 30, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
      key_in[3] = 1'b0;
      run_expect("k3_rel", 40, 30, 4'b0000, 4'b1000, 4'b1100, 4'b0100);

      // Reset mid-debounce on key 0 while key 2 is held
      goto_phase(0);
      key_in[0] = 1'b1;
      run_expect("k0_prereset", 25, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      rst_n = 1'b0;
      step();
      check("mid_rst_key_state", key_state, 4'b0000);
      check("mid_rst_press", press_pulse, 4'b0000);
      check("mid_rst_release", release_pulse, 4'b0000);
      check("mid_rst_tick", sample_tick, 1'b0);
      rst_n = 1'b1;
      cyc   = 0;
      run_expect("requal", 40, 30, 4'b0101, 4'b0000, 4'b0000, 4'b0101);

      // Whole-run properties
      check("press_release_overlap", overlap_seen, 4'b0000);
`ifndef KEY_REPEAT_EN
      check("repeat_never", rep_seen, 4'b0000);
`endif

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised successor to the single-key sampler: N independent key/button channels with a shared sample-tick generator.
- Each channel gets a 2-FF synchroniser, a stable-count debounce filter, a debounced level output, and one-clock press/release pulses.
- Sits between raw board pushbuttons and the UI/control FSMs.

Parameters:
NKEY, 4, number of key channels (1..16)
SR, 999, sample period reload; one sample tick every SR+1 clocks
STABLE, 3, consecutive differing samples required to accept a new level (1..15)
ACTIVE_LOW, 0, 1 = raw keys are pressed-low; inputs are inverted after synchronisation
LONG_TICKS, 50, ticks held before the first repeat pulse (used only with KEY_REPEAT_EN)
REPEAT_TICKS, 10, ticks between subsequent repeat pulses (used only with KEY_REPEAT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
key_in  input  NKEY  raw asynchronous key levels
sample_tick  output  1  one-clock strobe each sample instant
key_state  output  NKEY  debounced level, 1 = pressed
press_pulse  output  NKEY  one-clock pulse on debounced 0->1
release_pulse  output  NKEY  one-clock pulse on debounced 1->0
repeat_pulse  output  NKEY  auto-repeat strobe (constant 0 without KEY_REPEAT_EN)

Behaviour:
- Reset: one clock, synchronous reset (rst_n sampled low at posedge clk), active low. All logic is clocked on posedge clk; no other clock.
- Reset values:
  - Tick counter = SR.
  - Synchronisers = inactive level (1 if ACTIVE_LOW, else 0), so no false press appears after reset.
  - All stable counters = 0.
  - key_state, press_pulse, release_pulse, repeat_pulse, sample_tick = 0.
- Tick generator:
  - Down-counter of width $clog2(SR+1).
  - Reloads SR when it reaches 0; sample_tick = 1 in the cycle the counter is 0.
  - First tick falls SR clocks after rst_n is first sampled high; thereafter the period is exactly SR+1.
  - SR=0 gives a tick every clock.
- Synchroniser: key_in passes through 2 flops, then the optional ACTIVE_LOW inversion, giving k_s.
- Per-channel filter, acting only in tick cycles:
  - k_s == key_state: stable counter cleared.
  - k_s != key_state and counter+1 < STABLE: counter increments.
  - k_s != key_state and counter+1 == STABLE: key_state toggles and counter clears.
  - A differing run of fewer than STABLE ticks produces no change.
  - Counter width is $clog2(STABLE+1) and it never wraps.
- Pulses:
  - press_pulse[i] / release_pulse[i] are registered and high for exactly the one clock after the tick in which key_state[i] toggles, i.e. the first clock key_state shows the new value.
  - They are never high together on the same channel.
- Channels are fully independent. Simultaneous events on multiple channels in one tick produce simultaneous pulses.
- Latency from a clean edge on key_in to the pulse: 2 sync clocks + wait to the next tick (0..SR clocks) + (STABLE-1)*(SR+1) clocks + 1 clock.
- Reset mid-debounce: all partial counts are discarded and no pulse is emitted. A key held through reset is re-qualified normally, producing a press_pulse after STABLE ticks.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each channel has a hold counter of $clog2(LONG_TICKS+1) bits, cleared whenever key_state[i]=0 and incremented on ticks while key_state[i]=1.
  - When the hold count reaches LONG_TICKS, repeat_pulse[i] is asserted for one clock (aligned like press_pulse) and the counter reloads to LONG_TICKS-REPEAT_TICKS.
  - Repeats therefore occur every REPEAT_TICKS ticks thereafter.
  - Release stops repeats immediately.
- Undefined: repeat_pulse is tied to 0 and no hold counters are synthesised; LONG_TICKS and REPEAT_TICKS are ignored.

Test Plan:
- Config for all scenarios: NKEY=4, SR=9, STABLE=3, ACTIVE_LOW=0.
- Reset release -> all outputs 0; first sample_tick 9 clocks after rst_n high, then every 10 clocks; no pulses for 200 clocks with key_in=0.
- key_in[0] 0->1 and held -> press_pulse[0] high exactly one clock, key_state[0]=1 from that clock; release -> one release_pulse[0] after 3 ticks.
- key_in[1] glitch high for 15 clocks (spans at most 2 ticks) -> key_state and pulses stay 0; counter resets on return.
- key_in[2], key_in[3] pressed in the same clock -> press_pulse[2] and press_pulse[3] asserted in the same clock.
- Hold key_in[0] 25 clocks, assert rst_n=0 one clock, keep held -> no pulse before reset, outputs 0 after reset, press_pulse[0] fires 3 ticks later.
- With KEY_REPEAT_EN, LONG_TICKS=5, REPEAT_TICKS=2, hold key 1 -> repeat_pulse[1] at press tick +5 ticks, then every 2 ticks; release stops repeats; without the macro repeat_pulse stays 0.
